// File: rtl/ram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between
// requesters A and B, one access in flight at a time.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   a_req_*         A command channel (valid/ready, we, addr, wdata)
//   a_rsp_*         A response channel (valid/ready, rdata)
//   b_req_*,b_rsp_* identical set for requester B
//   mem_we/addr/wdata  drive the RAM write_en, addr, data_in
//   mem_rdata       RAM data_out (combinational, = wdata on write)
module ram_rr_arbiter #(
   parameter int AW = 3,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          a_req_valid,
   output logic          a_req_ready,
   input  logic          a_req_we,
   input  logic [AW-1:0] a_req_addr,
   input  logic [DW-1:0] a_req_wdata,
   output logic          a_rsp_valid,
   input  logic          a_rsp_ready,
   output logic [DW-1:0] a_rsp_rdata,
   input  logic          b_req_valid,
   output logic          b_req_ready,
   input  logic          b_req_we,
   input  logic [AW-1:0] b_req_addr,
   input  logic [DW-1:0] b_req_wdata,
   output logic          b_rsp_valid,
   input  logic          b_rsp_ready,
   output logic [DW-1:0] b_rsp_rdata,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;

   state_t state;
   logic   prio;
   logic   gnt;
   logic   mem_we_q;
   logic   pick_a;
   logic   pick_b;
   logic   idle;

   always_comb begin
      pick_a = 1'b0;
      pick_b = 1'b0;
      unique case (1'b1)
         (a_req_valid && !b_req_valid): pick_a = 1'b1;
         (!a_req_valid && b_req_valid): pick_b = 1'b1;
         (a_req_valid && b_req_valid): begin
            pick_a = !prio;
            pick_b = prio;
         end
         default: ;
      endcase
   end

   // Ready is withheld while reset is asserted so nothing
   // handshakes on a reset edge.
   assign idle        = (state == IDLE) && rst_n;
   assign a_req_ready = idle && pick_a;
   assign b_req_ready = idle && pick_b;

   // Gating with rst_n keeps a write from committing when
   // reset lands on its ACCESS edge.
   assign mem_we = mem_we_q && rst_n;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         prio        <= 1'b0;
         gnt         <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         a_rsp_valid <= 1'b0;
         b_rsp_valid <= 1'b0;
         a_rsp_rdata <= '0;
         b_rsp_rdata <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (a_req_ready) begin
                  gnt       <= 1'b0;
                  prio      <= 1'b1;
                  mem_we_q  <= a_req_we;
                  mem_addr  <= a_req_addr;
                  mem_wdata <= a_req_wdata;
                  state     <= ACCESS;
               end else if (b_req_ready) begin
                  gnt       <= 1'b1;
                  prio      <= 1'b0;
                  mem_we_q  <= b_req_we;
                  mem_addr  <= b_req_addr;
                  mem_wdata <= b_req_wdata;
                  state     <= ACCESS;
               end
            end
            ACCESS: begin
               mem_we_q <= 1'b0;
               state    <= RESP;
               if (gnt) begin
                  b_rsp_rdata <= mem_rdata;
                  b_rsp_valid <= 1'b1;
               end else begin
                  a_rsp_rdata <= mem_rdata;
                  a_rsp_valid <= 1'b1;
               end
            end
            RESP: begin
               if (gnt && b_rsp_ready) begin
                  b_rsp_valid <= 1'b0;
                  state       <= IDLE;
               end else if (!gnt && a_rsp_ready) begin
                  a_rsp_valid <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Directed bench for ram_rr_arbiter with a behavioural
// 8x8 single-port RAM attached to the mem_* port.
module tb_ram_rr_arbiter;

   logic       clk;
   logic       rst_n;
   logic       a_req_valid;
   logic       a_req_ready;
   logic       a_req_we;
   logic [2:0] a_req_addr;
   logic [7:0] a_req_wdata;
   logic       a_rsp_valid;
   logic       a_rsp_ready;
   logic [7:0] a_rsp_rdata;
   logic       b_req_valid;
   logic       b_req_ready;
   logic       b_req_we;
   logic [2:0] b_req_addr;
   logic [7:0] b_req_wdata;
   logic       b_rsp_valid;
   logic       b_rsp_ready;
   logic [7:0] b_rsp_rdata;
   logic       mem_we;
   logic [2:0] mem_addr;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata;

   logic [7:0] ram [0:7];
   int         checks;
   int         fails;
   int         we_cnt;

   ram_rr_arbiter #(.AW(3), .DW(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .a_req_valid (a_req_valid),
      .a_req_ready (a_req_ready),
      .a_req_we    (a_req_we),
      .a_req_addr  (a_req_addr),
      .a_req_wdata (a_req_wdata),
      .a_rsp_valid (a_rsp_valid),
      .a_rsp_ready (a_rsp_ready),
      .a_rsp_rdata (a_rsp_rdata),
      .b_req_valid (b_req_valid),
      .b_req_ready (b_req_ready),
      .b_req_we    (b_req_we),
      .b_req_addr  (b_req_addr),
      .b_req_wdata (b_req_wdata),
      .b_rsp_valid (b_rsp_valid),
      .b_rsp_ready (b_rsp_ready),
      .b_rsp_rdata (b_rsp_rdata),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;
   assign mem_rdata = mem_we ? mem_wdata : ram[mem_addr];

   initial we_cnt = 0;
   always @(negedge clk) if (mem_we === 1'b1) we_cnt++;

   initial begin
      #200000;
      $display("FAIL watchdog: sim time limit reached");
      $fatal(1, "watchdog");
   end

   // One complete transaction on side sb (0=A, 1=B).
   // Starts and ends 1 time unit after a posedge.
   task automatic op(input bit sb, input bit we,
                     input logic [2:0] ad,
                     input logic [7:0] wd,
                     output logic [7:0] rd,
                     output int lat, output bit ok);
      bit got;
      ok  = 1'b0;
      lat = 0;
      rd  = '0;
      got = 1'b0;
      if (sb) begin
         b_req_valid = 1'b1;
         b_req_we    = we;
         b_req_addr  = ad;
         b_req_wdata = wd;
         b_rsp_ready = 1'b1;
      end else begin
         a_req_valid = 1'b1;
         a_req_we    = we;
         a_req_addr  = ad;
         a_req_wdata = wd;
         a_rsp_ready = 1'b1;
      end
      for (int i = 0; i < 20 && !got; i++) begin
         #1;
         got = sb ? b_req_ready : a_req_ready;
         @(posedge clk);
         #1;
      end
      a_req_valid = 1'b0;
      b_req_valid = 1'b0;
      if (got) begin
         lat = 1;
         got = 1'b0;
         for (int i = 0; i < 20 && !got; i++) begin
            #1;
            got = sb ? b_rsp_valid : a_rsp_valid;
            if (got) rd = sb ? b_rsp_rdata : a_rsp_rdata;
            @(posedge clk);
            #1;
            if (!got) lat++;
         end
         ok = got;
      end
      a_rsp_ready = 1'b0;
      b_rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] outs;
      rst_n       = 1'b0;
      a_req_valid = 1'b1;
      b_req_valid = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(posedge clk);
         #1;
         outs = {a_rsp_valid, b_rsp_valid, a_rsp_rdata,
                 b_rsp_rdata, mem_we, mem_addr, mem_wdata,
                 a_req_ready, b_req_ready};
         checks++;
         if (outs !== 32'h0) begin
            fails++;
            $display("FAIL reset_outs cyc%0d: got %h want 0",
                     c, outs);
         end
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if ({a_req_ready, b_req_ready} !== 2'b10) begin
         fails++;
         $display("FAIL reset_first_grant: got %b want 10",
                  {a_req_ready, b_req_ready});
      end
      a_req_valid = 1'b0;
      b_req_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_write_read();
      logic [7:0] rd;
      int lat;
      bit ok;
      op(1'b0, 1'b1, 3'd3, 8'hA5, rd, lat, ok);
      checks++;
      if (!ok || rd !== 8'hA5 || lat != 2) begin
         fails++;
         $display("FAIL t2_write: ok %0d rd %h lat %0d want 1 a5 2",
                  ok, rd, lat);
      end
      op(1'b0, 1'b0, 3'd3, 8'h00, rd, lat, ok);
      checks++;
      if (!ok || rd !== 8'hA5) begin
         fails++;
         $display("FAIL t2_read: ok %0d rd %h want 1 a5", ok, rd);
      end
      checks++;
      if (lat != 2) begin
         fails++;
         $display("FAIL t2_latency: got %0d want 2", lat);
      end
   endtask

   task automatic test_alternate();
      logic [7:0] rd;
      int lat;
      bit ok;
      int k;
      bit side;
      // Preload; last op by B leaves prio on A.
      op(1'b0, 1'b1, 3'd0, 8'h10, rd, lat, ok);
      op(1'b1, 1'b1, 3'd2, 8'h22, rd, lat, ok);
      checks++;
      if (!ok) begin
         fails++;
         $display("FAIL t3_preload: ok %0d want 1", ok);
      end
      a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 3'd0;
      b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 3'd2;
      a_rsp_ready = 1'b1;
      b_rsp_ready = 1'b1;
      k = 0;
      for (int c = 0; c < 40 && k < 4; c++) begin
         #1;
         if (a_req_ready && b_req_ready) begin
            checks++;
            fails++;
            $display("FAIL t3_both_ready: got 11 want not 11");
         end else if (a_req_ready || b_req_ready) begin
            side = b_req_ready;
            checks++;
            if (side !== k[0]) begin
               fails++;
               $display("FAIL t3_grant%0d: got %0d want %0d",
                        k, side, k[0]);
            end
            k++;
         end
         if (a_rsp_valid) begin
            checks++;
            if (a_rsp_rdata !== 8'h10) begin
               fails++;
               $display("FAIL t3_a_rdata: got %h want 10",
                        a_rsp_rdata);
            end
         end
         if (b_rsp_valid) begin
            checks++;
            if (b_rsp_rdata !== 8'h22) begin
               fails++;
               $display("FAIL t3_b_rdata: got %h want 22",
                        b_rsp_rdata);
            end
         end
         @(posedge clk);
         #1;
      end
      a_req_valid = 1'b0;
      b_req_valid = 1'b0;
      checks++;
      if (k != 4) begin
         fails++;
         $display("FAIL t3_grant_count: got %0d want 4", k);
      end
      repeat (3) @(posedge clk);
      #1;
      a_rsp_ready = 1'b0;
      b_rsp_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      logic [7:0] rd;
      int lat;
      bit ok;
      op(1'b1, 1'b1, 3'd7, 8'h3C, rd, lat, ok);
      b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 3'd7;
      b_rsp_ready = 1'b0;
      #1;
      checks++;
      if (b_req_ready !== 1'b1) begin
         fails++;
         $display("FAIL t4_b_accept: got %b want 1", b_req_ready);
      end
      @(posedge clk);
      #1;
      b_req_valid = 1'b0;
      a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 3'd0;
      #1;
      checks++;
      if (a_req_ready !== 1'b0) begin
         fails++;
         $display("FAIL t4_a_ready_access: got %b want 0",
                  a_req_ready);
      end
      @(posedge clk);
      #1;
      for (int c = 0; c < 5; c++) begin
         #1;
         checks++;
         if ({b_rsp_valid, b_rsp_rdata, a_req_ready} !==
             {1'b1, 8'h3C, 1'b0}) begin
            fails++;
            $display("FAIL t4_hold%0d: v %b d %h ar %b want 1 3c 0",
                     c, b_rsp_valid, b_rsp_rdata, a_req_ready);
         end
         @(posedge clk);
         #1;
      end
      b_rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      b_rsp_ready = 1'b0;
      #1;
      checks++;
      if ({b_rsp_valid, a_req_ready} !== 2'b01) begin
         fails++;
         $display("FAIL t4_release: got %b want 01",
                  {b_rsp_valid, a_req_ready});
      end
      a_req_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_access();
      logic [7:0] rd;
      int lat;
      bit ok;
      op(1'b0, 1'b1, 3'd1, 8'h5A, rd, lat, ok);
      a_req_valid = 1'b1; a_req_we = 1'b1;
      a_req_addr = 3'd1; a_req_wdata = 8'hFF;
      a_rsp_ready = 1'b1;
      #1;
      checks++;
      if (a_req_ready !== 1'b1) begin
         fails++;
         $display("FAIL t5_accept: got %b want 1", a_req_ready);
      end
      @(posedge clk);
      #1;
      a_req_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      checks++;
      if (mem_we !== 1'b0) begin
         fails++;
         $display("FAIL t5_we_in_reset: got %b want 0", mem_we);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         checks++;
         if (a_rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL t5_no_rsp%0d: got %b want 0",
                     c, a_rsp_valid);
         end
         @(posedge clk);
         #1;
      end
      a_rsp_ready = 1'b0;
      op(1'b0, 1'b0, 3'd1, 8'h00, rd, lat, ok);
      checks++;
      if (!ok || rd !== 8'h5A) begin
         fails++;
         $display("FAIL t5_old_value: ok %0d rd %h want 1 5a",
                  ok, rd);
      end
   endtask

   task automatic test_cross_rw();
      logic [7:0] rd;
      int lat;
      bit ok;
      int c0;
      c0 = we_cnt;
      op(1'b1, 1'b1, 3'd5, 8'h11, rd, lat, ok);
      checks++;
      if (!ok || rd !== 8'h11 || we_cnt - c0 != 1) begin
         fails++;
         $display("FAIL t6_write: ok %0d rd %h we %0d want 1 11 1",
                  ok, rd, we_cnt - c0);
      end
      c0 = we_cnt;
      op(1'b0, 1'b0, 3'd5, 8'h00, rd, lat, ok);
      checks++;
      if (!ok || rd !== 8'h11 || we_cnt - c0 != 0) begin
         fails++;
         $display("FAIL t6_read: ok %0d rd %h we %0d want 1 11 0",
                  ok, rd, we_cnt - c0);
      end
   endtask

   initial begin
      checks      = 0;
      fails       = 0;
      rst_n       = 1'b0;
      a_req_valid = 1'b0;
      a_req_we    = 1'b0;
      a_req_addr  = '0;
      a_req_wdata = '0;
      a_rsp_ready = 1'b0;
      b_req_valid = 1'b0;
      b_req_we    = 1'b0;
      b_req_addr  = '0;
      b_req_wdata = '0;
      b_rsp_ready = 1'b0;
      test_reset();
      test_write_read();
      test_alternate();
      test_backpressure();
      test_reset_access();
      test_cross_rw();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               checks, fails);
      $finish;
   end

endmodule
